// File: rtl/charge_controller_param_if.sv
// Keypad-to-controller and controller-to-display/relay signal bundle for the
// coin-operated charger. The keypad side is the master and the controller is the slave.
interface charge_controller_param_if #(
  parameter int unsigned MONEY_W = 5,
  parameter int unsigned TIME_W  = 6
);
  logic [3:0]         key_value;
  logic               press;
  logic               no_display;
  logic               timing;
  logic [MONEY_W-1:0] all_money;
  logic [TIME_W-1:0]  remaining_time;
  logic [1:0]         state;
  logic [2:0]         digit_count;
  logic               charge_done;

  modport master (
    output key_value, press,
    input  no_display, timing, all_money, remaining_time, state, digit_count, charge_done
  );

  modport slave (
    input  key_value, press,
    output no_display, timing, all_money, remaining_time, state, digit_count, charge_done
  );
endinterface

// File: rtl/charge_controller_param.sv
// Coin-operated charger controller. It takes keypad strobes, accumulates a decimal
// payment, and then counts the charging time down. Every output is registered.
module charge_controller_param #(
  parameter int unsigned TICK_DIV       = 1000,
  parameter int unsigned N_DIGITS       = 2,
  parameter int unsigned MAX_MONEY      = 20,
  parameter int unsigned SEC_PER_UNIT   = 2,
  parameter int unsigned IDLE_TIMEOUT_S = 10,
  parameter int unsigned MONEY_W        = 5,
  parameter int unsigned TIME_W         = 6
) (
  input logic                      clk,
  input logic                      rst_n,
  charge_controller_param_if.slave kbus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READY  = 2'd1,
    S_ENTRY  = 2'd2,
    S_CHARGE = 2'd3
  } state_e;

  localparam logic [3:0] KEY_START   = 4'hA;
  localparam logic [3:0] KEY_CLEAR   = 4'hB;
  localparam logic [3:0] KEY_CONFIRM = 4'hC;
  localparam logic [3:0] KEY_BACK    = 4'hD;

  localparam int unsigned PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned IDLE_LIMIT = IDLE_TIMEOUT_S * TICK_DIV;
  localparam int unsigned IDLE_W     = (IDLE_LIMIT > 1) ? $clog2(IDLE_LIMIT) : 1;
  localparam int unsigned SUM_W      = MONEY_W + 4;

  localparam logic [PRESC_W-1:0] PRESC_TOP = PRESC_W'(TICK_DIV - 1);
  localparam logic [IDLE_W-1:0]  IDLE_TOP  = IDLE_W'(IDLE_LIMIT - 1);
  localparam logic [2:0]         MAX_DIG   = 3'(N_DIGITS);
  localparam logic [SUM_W-1:0]   SAT_SUM   = SUM_W'(MAX_MONEY);

  state_e               state_q, state_d;
  logic [MONEY_W-1:0]   money_q, money_d;
  logic [2:0]           digits_q, digits_d;
  logic [TIME_W-1:0]    time_q, time_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [IDLE_W-1:0]    idle_q, idle_d;
  logic                 no_display_q, no_display_d;
  logic                 timing_q, timing_d;
  logic                 done_q, done_d;

  logic                 key_is_digit;
  logic                 idle_expired;
  logic [SUM_W-1:0]     money_sum;
  logic [MONEY_W-1:0]   money_next_digit;
  logic [MONEY_W-1:0]   money_div10;
  logic [TIME_W-1:0]    time_load;

  // The digit is appended at a width that cannot overflow, and it is clamped
  // only afterwards. Saturation therefore always lands exactly on MAX_MONEY.
  always_comb begin
    key_is_digit     = (kbus.key_value <= 4'd9);
    idle_expired     = (idle_q == IDLE_TOP);
    money_sum        = ({4'd0, money_q} * SUM_W'(10)) + SUM_W'(kbus.key_value);
    money_next_digit = (money_sum > SAT_SUM) ? MONEY_W'(MAX_MONEY) : money_sum[MONEY_W-1:0];
    money_div10      = MONEY_W'({4'd0, money_q} / SUM_W'(10));
    time_load        = TIME_W'(money_q * SEC_PER_UNIT);
  end

  // NOTE: every next-state signal is given its hold value first. With that default
  // no branch can leave a signal unassigned, so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    money_d  = money_q;
    digits_d = digits_q;
    time_d   = time_q;
    presc_d  = presc_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (kbus.press && kbus.key_value == KEY_START) begin
          state_d = S_READY;
        end
      end

      S_READY: begin
        if (kbus.press) begin
          if (key_is_digit) begin
            state_d  = S_ENTRY;
            money_d  = money_next_digit;
            digits_d = 3'd1;
          end
        end else if (idle_expired) begin
          state_d = S_IDLE;
          money_d  = '0;
          digits_d = '0;
        end
      end

      S_ENTRY: begin
        if (kbus.press) begin
          if (key_is_digit) begin
            if (digits_q < MAX_DIG) begin
              money_d  = money_next_digit;
              digits_d = digits_q + 3'd1;
            end
          end else begin
            unique case (kbus.key_value)
              KEY_CLEAR: begin
                state_d  = S_READY;
                money_d  = '0;
                digits_d = '0;
              end
              KEY_CONFIRM: begin
                if (money_q != '0) begin
                  state_d = S_CHARGE;
                  time_d  = time_load;
                  presc_d = '0;
                end
              end
              KEY_BACK: begin
                money_d  = money_div10;
                digits_d = digits_q - 3'd1;
                if (digits_q == 3'd1) begin
                  state_d = S_READY;
                end
              end
              default: ;
            endcase
          end
        end else if (idle_expired) begin
          state_d  = S_IDLE;
          money_d  = '0;
          digits_d = '0;
        end
      end

      S_CHARGE: begin
        // Keys are deliberately not decoded here. Only reset can end a charge early.
        if (presc_q == PRESC_TOP) begin
          presc_d = '0;
          time_d  = time_q - TIME_W'(1);
          if (time_q == TIME_W'(1)) begin
            state_d  = S_READY;
            money_d  = '0;
            digits_d = '0;
            done_d   = 1'b1;
          end
        end else begin
          presc_d = presc_q + PRESC_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Any strobe, even one for an ignored key, counts as user activity.
    if (kbus.press || (state_d != state_q) ||
        !((state_q == S_READY) || (state_q == S_ENTRY))) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q + IDLE_W'(1);
    end

    no_display_d = (state_d == S_IDLE);
    timing_d     = (state_d == S_CHARGE);
  end

  // NOTE: the state registers use non-blocking assignments. All flops then sample
  // their _d values from before the edge, whatever order the statements run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      money_q      <= '0;
      digits_q     <= '0;
      time_q       <= '0;
      presc_q      <= '0;
      idle_q       <= '0;
      no_display_q <= 1'b1;
      timing_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      money_q      <= money_d;
      digits_q     <= digits_d;
      time_q       <= time_d;
      presc_q      <= presc_d;
      idle_q       <= idle_d;
      no_display_q <= no_display_d;
      timing_q     <= timing_d;
      done_q       <= done_d;
    end
  end

  // The display shows remaining_time only while charging, so it is masked outside CHARGE.
  assign kbus.state          = state_q;
  assign kbus.all_money      = money_q;
  assign kbus.digit_count    = digits_q;
  assign kbus.remaining_time = (state_q == S_CHARGE) ? time_q : '0;
  assign kbus.no_display     = no_display_q;
  assign kbus.timing         = timing_q;
  assign kbus.charge_done    = done_q;

endmodule

// File: tb/tb_charge_controller_param.sv
// Scoreboard bench for charge_controller_param. It uses a fast tick and a short timeout.
// A second, wider instance covers the case with three digits and a larger saturation value.
module tb_charge_controller_param;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  charge_controller_param_if #(.MONEY_W(5), .TIME_W(6)) bus ();
  charge_controller_param_if #(.MONEY_W(8), .TIME_W(9)) bus_w ();

  charge_controller_param #(
    .TICK_DIV(4), .N_DIGITS(2), .MAX_MONEY(20), .SEC_PER_UNIT(2),
    .IDLE_TIMEOUT_S(3), .MONEY_W(5), .TIME_W(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .kbus(bus.slave)
  );

  charge_controller_param #(
    .TICK_DIV(4), .N_DIGITS(3), .MAX_MONEY(250), .SEC_PER_UNIT(2),
    .IDLE_TIMEOUT_S(3), .MONEY_W(8), .TIME_W(9)
  ) dut_w (
    .clk(clk), .rst_n(rst_n), .kbus(bus_w.slave)
  );

  typedef struct packed {
    logic [1:0] st;
    logic       nd;
    logic       tm;
    logic [4:0] money;
    logic [5:0] rt;
    logic [2:0] dc;
    logic       done;
  } obs_t;

  typedef struct packed {
    logic [1:0] st;
    logic [7:0] money;
    logic [8:0] rt;
    logic [2:0] dc;
  } obs_w_t;

  typedef struct {
    string name;
    obs_t  v;
  } exp_t;

  typedef struct {
    string  name;
    obs_w_t v;
  } exp_w_t;

  exp_t   sb   [$];
  exp_w_t sb_w [$];
  int     checks = 0;
  int     errors = 0;

  function automatic obs_t mk(input int st, input int money, input int rt, input int dc, input int done);
    obs_t o;
    o.st    = 2'(st);
    o.nd    = (st == 0);
    o.tm    = (st == 3);
    o.money = 5'(money);
    o.rt    = 6'(rt);
    o.dc    = 3'(dc);
    o.done  = 1'(done);
    return o;
  endfunction

  function automatic exp_t ex(input string n, input obs_t v);
    exp_t e;
    e.name = n;
    e.v    = v;
    return e;
  endfunction

  function automatic exp_w_t ex_w(input string n, input int st, input int money, input int rt, input int dc);
    exp_w_t e;
    e.name     = n;
    e.v.st     = 2'(st);
    e.v.money  = 8'(money);
    e.v.rt     = 9'(rt);
    e.v.dc     = 3'(dc);
    return e;
  endfunction

  function automatic obs_t snap();
    obs_t o;
    o.st    = bus.state;
    o.nd    = bus.no_display;
    o.tm    = bus.timing;
    o.money = bus.all_money;
    o.rt    = bus.remaining_time;
    o.dc    = bus.digit_count;
    o.done  = bus.charge_done;
    return o;
  endfunction

  function automatic obs_w_t snap_w();
    obs_w_t o;
    o.st    = bus_w.state;
    o.money = bus_w.all_money;
    o.rt    = bus_w.remaining_time;
    o.dc    = bus_w.digit_count;
    return o;
  endfunction

  task automatic key(input logic [3:0] k);
    @(negedge clk);
    bus.key_value = k;
    bus.press     = 1'b1;
    @(negedge clk);
    bus.press     = 1'b0;
  endtask

  task automatic key_w(input logic [3:0] k);
    @(negedge clk);
    bus_w.key_value = k;
    bus_w.press     = 1'b1;
    @(negedge clk);
    bus_w.press     = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.press   = 1'b0;
    bus_w.press = 1'b0;
    rst_n       = 1'b0;
    @(negedge clk);
    rst_n       = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] keys [3];
    exp_t e;
    obs_t got;
    repeat (2) @(negedge clk);
    sb.push_back(ex("reset_held", mk(0, 0, 0, 0, 0)));
    e = sb.pop_front(); got = snap(); checks++;
    if (got !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
    rst_n = 1'b1;
    keys = '{4'd5, 4'hE, 4'hC};
    foreach (keys[i]) begin
      sb.push_back(ex($sformatf("idle_ignores_%h", keys[i]), mk(0, 0, 0, 0, 0)));
      key(keys[i]);
      e = sb.pop_front(); got = snap(); checks++;
      if (got !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
    end
  endtask

  task automatic test_charge();
    logic [3:0] keys [4];
    exp_t e;
    obs_t got;
    do_reset();
    keys = '{4'hA, 4'd1, 4'd5, 4'hC};
    sb.push_back(ex("chg_start",   mk(1, 0, 0, 0, 0)));
    sb.push_back(ex("chg_digit1",  mk(2, 1, 0, 1, 0)));
    sb.push_back(ex("chg_digit5",  mk(2, 15, 0, 2, 0)));
    sb.push_back(ex("chg_confirm", mk(3, 15, 30, 2, 0)));
    foreach (keys[i]) begin
      key(keys[i]);
      e = sb.pop_front(); got = snap(); checks++;
      if (got !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
    end
    for (int c = 1; c <= 121; c++) begin
      if (c < 120)       sb.push_back(ex($sformatf("chg_cyc%0d", c), mk(3, 15, 30 - c / 4, 2, 0)));
      else if (c == 120) sb.push_back(ex("chg_done_pulse", mk(1, 0, 0, 0, 1)));
      else               sb.push_back(ex("chg_done_clear", mk(1, 0, 0, 0, 0)));
      @(negedge clk);
      e = sb.pop_front(); got = snap(); checks++;
      if (got !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
    end
  endtask

  task automatic test_entry();
    logic [3:0] keys [7];
    exp_t e;
    obs_t got;
    do_reset();
    keys = '{4'hA, 4'd9, 4'hE, 4'd9, 4'd9, 4'hD, 4'hD};
    sb.push_back(ex("ent_start",     mk(1, 0, 0, 0, 0)));
    sb.push_back(ex("ent_9",         mk(2, 9, 0, 1, 0)));
    sb.push_back(ex("ent_undef_key", mk(2, 9, 0, 1, 0)));
    sb.push_back(ex("ent_99_sat",    mk(2, 20, 0, 2, 0)));
    sb.push_back(ex("ent_extra_9",   mk(2, 20, 0, 2, 0)));
    sb.push_back(ex("ent_back1",     mk(2, 2, 0, 1, 0)));
    sb.push_back(ex("ent_back2",     mk(1, 0, 0, 0, 0)));
    foreach (keys[i]) begin
      key(keys[i]);
      e = sb.pop_front(); got = snap(); checks++;
      if (got !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    obs_t got;
    do_reset();
    sb.push_back(ex("to_start", mk(1, 0, 0, 0, 0)));
    key(4'hA);
    e = sb.pop_front(); got = snap(); checks++;
    if (got !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
    for (int c = 1; c <= 12; c++) begin
      sb.push_back(ex($sformatf("to_wait%0d", c), (c < 12) ? mk(1, 0, 0, 0, 0) : mk(0, 0, 0, 0, 0)));
      @(negedge clk);
      e = sb.pop_front(); got = snap(); checks++;
      if (got !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
    end
    sb.push_back(ex("to_restart", mk(1, 0, 0, 0, 0)));
    key(4'hA);
    e = sb.pop_front(); got = snap(); checks++;
    if (got !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
    for (int c = 1; c <= 11; c++) begin
      sb.push_back(ex($sformatf("to_pre%0d", c), mk(1, 0, 0, 0, 0)));
      @(negedge clk);
      e = sb.pop_front(); got = snap(); checks++;
      if (got !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
    end
    // This strobe is sampled on the same edge that would otherwise expire the counter.
    sb.push_back(ex("to_press_wins", mk(1, 0, 0, 0, 0)));
    bus.key_value = 4'hB;
    bus.press     = 1'b1;
    @(negedge clk);
    bus.press     = 1'b0;
    e = sb.pop_front(); got = snap(); checks++;
    if (got !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
    for (int c = 1; c <= 12; c++) begin
      sb.push_back(ex($sformatf("to_post%0d", c), (c < 12) ? mk(1, 0, 0, 0, 0) : mk(0, 0, 0, 0, 0)));
      @(negedge clk);
      e = sb.pop_front(); got = snap(); checks++;
      if (got !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
    end
  endtask

  task automatic test_confirm();
    logic [3:0] keys [9];
    exp_t e;
    obs_t got;
    do_reset();
    keys = '{4'hA, 4'hC, 4'd3, 4'hB, 4'd0, 4'hC, 4'hD, 4'd3, 4'hC};
    sb.push_back(ex("cf_start",        mk(1, 0, 0, 0, 0)));
    sb.push_back(ex("cf_confirm_rdy",  mk(1, 0, 0, 0, 0)));
    sb.push_back(ex("cf_3",            mk(2, 3, 0, 1, 0)));
    sb.push_back(ex("cf_clear",        mk(1, 0, 0, 0, 0)));
    sb.push_back(ex("cf_0",            mk(2, 0, 0, 1, 0)));
    sb.push_back(ex("cf_confirm_zero", mk(2, 0, 0, 1, 0)));
    sb.push_back(ex("cf_back_zero",    mk(1, 0, 0, 0, 0)));
    sb.push_back(ex("cf_3b",           mk(2, 3, 0, 1, 0)));
    sb.push_back(ex("cf_confirm",      mk(3, 3, 6, 1, 0)));
    foreach (keys[i]) begin
      key(keys[i]);
      e = sb.pop_front(); got = snap(); checks++;
      if (got !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
    end
  endtask

  task automatic test_abort();
    logic [3:0] keys [3];
    logic [3:0] chg_keys [4];
    exp_t e;
    obs_t got;
    do_reset();
    keys = '{4'hA, 4'd5, 4'hC};
    sb.push_back(ex("ab_start",   mk(1, 0, 0, 0, 0)));
    sb.push_back(ex("ab_5",       mk(2, 5, 0, 1, 0)));
    sb.push_back(ex("ab_confirm", mk(3, 5, 10, 1, 0)));
    foreach (keys[i]) begin
      key(keys[i]);
      e = sb.pop_front(); got = snap(); checks++;
      if (got !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
    end
    chg_keys = '{4'hB, 4'd7, 4'hD, 4'hA};
    foreach (chg_keys[i]) begin
      sb.push_back(ex($sformatf("ab_key_in_charge_%h", chg_keys[i]), mk(3, 5, 10 - (2 * (i + 1)) / 4, 1, 0)));
      key(chg_keys[i]);
      e = sb.pop_front(); got = snap(); checks++;
      if (got !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
    end
    sb.push_back(ex("ab_async_reset", mk(0, 0, 0, 0, 0)));
    #1 rst_n = 1'b0;
    #1;
    e = sb.pop_front(); got = snap(); checks++;
    if (got !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(ex("ab_after_release", mk(0, 0, 0, 0, 0)));
    repeat (3) @(negedge clk);
    e = sb.pop_front(); got = snap(); checks++;
    if (got !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
  endtask

  task automatic test_wide();
    logic [3:0] keys [6];
    exp_w_t e;
    obs_w_t got;
    do_reset();
    keys = '{4'hA, 4'd1, 4'd2, 4'd3, 4'd4, 4'hC};
    sb_w.push_back(ex_w("w_start",   1, 0, 0, 0));
    sb_w.push_back(ex_w("w_1",       2, 1, 0, 1));
    sb_w.push_back(ex_w("w_12",      2, 12, 0, 2));
    sb_w.push_back(ex_w("w_123",     2, 123, 0, 3));
    sb_w.push_back(ex_w("w_4th_dig", 2, 123, 0, 3));
    sb_w.push_back(ex_w("w_confirm", 3, 123, 246, 3));
    foreach (keys[i]) begin
      key_w(keys[i]);
      e = sb_w.pop_front(); got = snap_w(); checks++;
      if (got !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
    end
    sb_w.push_back(ex_w("w_first_tick", 3, 123, 245, 3));
    repeat (4) @(negedge clk);
    e = sb_w.pop_front(); got = snap_w(); checks++;
    if (got !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.key_value   = 4'h0;
    bus.press       = 1'b0;
    bus_w.key_value = 4'h0;
    bus_w.press     = 1'b0;
    test_reset();
    test_charge();
    test_entry();
    test_timeout();
    test_confirm();
    test_abort();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
